// File: rtl/ex_stage.sv
// ex_stage: execute stage fed by the ID/EX pipeline register.
//   - Single-cycle ALU. ALU control is decoded here from ALUOp/funct.
//   - Sequential unsigned multu/divu unit, one iteration per cycle,
//     writing the HI/LO registers.
//   - stall holds ID/EX (en_reg = !stall) while multu/divu is in flight.
// Ports:
//   clk, rst (async, active-low)
//   ALUOp, ALUSrc, RegDst, rd1, rd2, extend_immed, rt, rd, funct : ID/EX outputs
//   alu_result, zero, write_reg : combinational results
//   stall, busy                 : pipeline hold / md unit iterating
//   hi_out, lo_out              : HI/LO registers
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ALUOp,
    input  logic              ALUSrc,
    input  logic              RegDst,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] extend_immed,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [4:0]        write_reg,
    output logic              stall,
    output logic              busy,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;     // multu: {partial, multiplier}; divu: {rem, quot}
    logic [DATA_W-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
    logic                div_q, div_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [DATA_W-1:0]   op_b;
    logic                md_op;

    // ---------------- ALU ----------------
    always_comb begin
        op_b      = ALUSrc ? extend_immed : rd2;
        write_reg = RegDst ? rd : rt;
        md_op     = (ALUOp == 2'b10) && (funct == 6'h19 || funct == 6'h1B);
        alu_result = '0;
        case (ALUOp)
            2'b01:   alu_result = rd1 - op_b;
            2'b10: begin
                case (funct)
                    6'h20, 6'h21: alu_result = rd1 + op_b;
                    6'h22, 6'h23: alu_result = rd1 - op_b;
                    6'h24:        alu_result = rd1 & op_b;
                    6'h25:        alu_result = rd1 | op_b;
                    6'h27:        alu_result = ~(rd1 | op_b);
                    6'h2A:        alu_result = DATA_W'($signed(rd1) < $signed(op_b));
                    6'h10:        alu_result = hi_q;
                    6'h12:        alu_result = lo_q;
                    default:      alu_result = '0;  // includes multu/divu
                endcase
            end
            default: alu_result = rd1 + op_b;       // 00 and 11
        endcase
        zero = (alu_result == '0);
    end

    // ---------------- one multiply/divide iteration ----------------
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     rem_sh;   // remainder after the left shift, one bit wider
    logic [DATA_W-1:0]   rem_sub;
    logic                rem_ge;
    logic [2*DATA_W-1:0] acc_step;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        rem_sh  = acc_q[2*DATA_W-1:DATA_W-1];
        rem_ge  = (rem_sh >= {1'b0, opnd_q});
        // When rem_ge holds the difference is below the divisor, so DATA_W bits suffice.
        rem_sub = rem_sh[DATA_W-1:0] - opnd_q;
        if (div_q)
            acc_step = rem_ge ? {rem_sub,            acc_q[DATA_W-2:0], 1'b1}
                              : {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        else
            acc_step = {mul_sum, acc_q[DATA_W-1:1]};
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                stall = md_op;
                if (md_op) begin
                    div_d   = (funct == 6'h1B);
                    opnd_d  = (funct == 6'h1B) ? rd2 : rd1;
                    acc_d   = {{DATA_W{1'b0}}, ((funct == 6'h1B) ? rd1 : rd2)};
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                busy  = 1'b1;
                acc_d = acc_step;
                if (cnt_q == CNT_W'(DATA_W-1)) begin
                    // Upper half is HI (product high / remainder), lower is LO.
                    hi_d    = acc_step[2*DATA_W-1:DATA_W];
                    lo_d    = acc_step[DATA_W-1:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // ID/EX loads the next instruction on this edge, so returning to
            // IDLE unconditionally cannot re-issue the finished op.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            stall = 1'b0;
            busy  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vectors, multu/divu latency and results,
// mid-operation reset, back-to-back md ops with ID/EX gated by !stall.
module tb_ex_stage;

    logic        clk, rst;
    logic [1:0]  ALUOp;
    logic        ALUSrc, RegDst;
    logic [31:0] rd1, rd2, extend_immed;
    logic [4:0]  rt, rd;
    logic [5:0]  funct;
    logic [31:0] alu_result, hi_out, lo_out;
    logic        zero, stall, busy;
    logic [4:0]  write_reg;

    int nchk = 0;
    int nerr = 0;

    ex_stage #(.DATA_W(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
        .rd1(rd1), .rd2(rd2), .extend_immed(extend_immed), .rt(rt), .rd(rd),
        .funct(funct), .alu_result(alu_result), .zero(zero), .write_reg(write_reg),
        .stall(stall), .busy(busy), .hi_out(hi_out), .lo_out(lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ALUOp  = 2'b10;
        ALUSrc = 1'b0;
        funct  = f;
        rd1    = a;
        rd2    = b;
    endtask

    // Call just after a posedge with the md op already driven. Counts stall/busy
    // cycles, checks HI/LO stay put while stalled, and returns at the negedge of
    // the first non-stalled (DONE) cycle.
    task automatic run_md(output int ns, output int nb, output logic hold_ok);
        logic [31:0] h0, l0;
        h0 = hi_out;
        l0 = lo_out;
        ns = 0;
        nb = 0;
        hold_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            ns++;
            if (busy) nb++;
            if (hi_out !== h0 || lo_out !== l0) hold_ok = 1'b0;
        end
    endtask

    int   ns, nb;
    logic hok;

    initial begin
        rst = 1'b0;
        rtype(6'h20, 32'd3, 32'd4);
        extend_immed = 32'h0;
        RegDst = 1'b0;
        rt = 5'd7;
        rd = 5'd9;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        chk("rst_hi",    hi_out, 32'h0);
        chk("rst_lo",    lo_out, 32'h0);
        chk("rst_alu",   alu_result, 32'd7);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ---------------- combinational ALU ----------------
        rtype(6'h20, 32'h7FFFFFFF, 32'h1);
        #1;
        chk("add_wrap", alu_result, 32'h80000000);
        chk("add_zero", {31'b0, zero}, 32'd0);
        rtype(6'h22, 32'd5, 32'd5);
        #1;
        chk("sub_res",  alu_result, 32'h0);
        chk("sub_zero", {31'b0, zero}, 32'd1);
        ALUOp = 2'b00; ALUSrc = 1'b1; extend_immed = 32'hFFFFFFFC; rd1 = 32'h10;
        #1 chk("lw_add", alu_result, 32'h0000000C);
        RegDst = 1'b1;
        #1 chk("wr_rd", {27'b0, write_reg}, 32'd9);
        RegDst = 1'b0;
        #1 chk("wr_rt", {27'b0, write_reg}, 32'd7);
        ALUOp = 2'b01; ALUSrc = 1'b0; rd1 = 32'd3; rd2 = 32'd5;
        #1 chk("beq_sub", alu_result, 32'hFFFFFFFE);
        rtype(6'h2A, 32'hFFFFFFFF, 32'h1);
        #1 chk("slt_neg", alu_result, 32'd1);
        rtype(6'h2A, 32'h1, 32'hFFFFFFFF);
        #1 chk("slt_pos", alu_result, 32'd0);
        rtype(6'h24, 32'hF0F0F0F0, 32'h0FF00FF0);
        #1 chk("and", alu_result, 32'h00F000F0);
        funct = 6'h25;
        #1 chk("or", alu_result, 32'hFFF0FFF0);
        funct = 6'h27;
        #1 chk("nor", alu_result, 32'h000F000F);
        funct = 6'h3F;
        #1 chk("bad_funct", alu_result, 32'h0);
        chk("nonmd_stall", {31'b0, stall}, 32'd0);

        // ---------------- multu max * max ----------------
        @(posedge clk); #1;
        rtype(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1 chk("multu_alu", alu_result, 32'h0);
        run_md(ns, nb, hok);
        chk("mul_stall", ns, 32'd33);
        chk("mul_busy",  nb, 32'd32);
        chk("mul_hold",  {31'b0, hok}, 32'd1);
        chk("mul_hi", hi_out, 32'hFFFFFFFE);
        chk("mul_lo", lo_out, 32'h00000001);
        @(posedge clk); #1;
        rtype(6'h10, 32'h0, 32'h0);
        #1 chk("mfhi", alu_result, 32'hFFFFFFFE);
        chk("mfhi_nostall", {31'b0, stall}, 32'd0);
        funct = 6'h12;
        #1 chk("mflo", alu_result, 32'h00000001);

        // ---------------- divu ----------------
        @(posedge clk); #1;
        rtype(6'h1B, 32'd100, 32'd7);
        run_md(ns, nb, hok);
        chk("div_stall", ns, 32'd33);
        chk("div_lo", lo_out, 32'd14);
        chk("div_hi", hi_out, 32'd2);
        @(posedge clk); #1;
        rtype(6'h1B, 32'h1234, 32'h0);
        run_md(ns, nb, hok);
        chk("div0_stall", ns, 32'd33);
        chk("div0_lo", lo_out, 32'hFFFFFFFF);
        chk("div0_hi", hi_out, 32'h00001234);

        // ---------------- reset in the middle of a multu ----------------
        @(posedge clk); #1;
        rtype(6'h19, 32'h00010000, 32'h00010003);
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (nb == 11) break;
        end
        chk("busy_cnt10", nb, 32'd11);
        rst = 1'b0;
        #1;
        chk("mrst_stall", {31'b0, stall}, 32'd0);
        chk("mrst_busy",  {31'b0, busy},  32'd0);
        chk("mrst_hi", hi_out, 32'h0);
        chk("mrst_lo", lo_out, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_md(ns, nb, hok);
        chk("rel_stall", ns, 32'd33);
        chk("rel_busy",  nb, 32'd32);
        chk("rel_hi", hi_out, 32'h00000001);
        chk("rel_lo", lo_out, 32'h00030000);

        // ---------------- back-to-back multu then divu ----------------
        @(posedge clk); #1;
        rtype(6'h19, 32'd3, 32'd5);
        run_md(ns, nb, hok);
        chk("b2b_mul_stall", ns, 32'd33);
        chk("b2b_mul_lo", lo_out, 32'd15);
        chk("b2b_mul_hi", hi_out, 32'd0);
        // DONE edge: ID/EX loads the divu immediately.
        @(posedge clk); #1;
        rtype(6'h1B, 32'hFFFFFFFF, 32'h10);
        run_md(ns, nb, hok);
        chk("b2b_div_stall", ns, 32'd33);
        chk("b2b_hold", {31'b0, hok}, 32'd1);
        chk("b2b_div_lo", lo_out, 32'h0FFFFFFF);
        chk("b2b_div_hi", hi_out, 32'h0000000F);
        @(posedge clk); #1;
        rtype(6'h20, 32'd1, 32'd1);
        #1 chk("b2b_idle", {31'b0, stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that sits directly downstream of the ID/EX pipeline register and consumes its registered outputs.
- Performs single-cycle ALU operations and resolves the ALU control internally from ALUOp/funct.
- Adds a sequential 32-iteration unsigned multiply/divide unit with HI/LO registers.
- Raises `stall` so the ID/EX register (driven with en_reg = !stall) holds its contents while a multu/divu is in flight.

Parameters:
- DATA_W, 32, datapath width; multu/divu iteration count equals DATA_W.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- ALUOp  in  2  00=add (lw/sw), 01=sub (beq), 10=R-type decode by funct, 11=add
- ALUSrc  in  1  1: operand B = extend_immed; 0: operand B = rd2
- RegDst  in  1  1: write_reg = rd; 0: write_reg = rt
- rd1  in  DATA_W  operand A
- rd2  in  DATA_W  register operand B
- extend_immed  in  DATA_W  sign-extended immediate
- rt  in  5  rt field
- rd  in  5  rd field
- funct  in  6  R-type function code
- alu_result  out  DATA_W  combinational result
- zero  out  1  alu_result == 0
- write_reg  out  5  destination register select
- stall  out  1  hold upstream registers
- busy  out  1  multiply/divide unit iterating
- hi_out  out  DATA_W  HI register
- lo_out  out  DATA_W  LO register

Behaviour:
- Operand B = ALUSrc ? extend_immed : rd2. write_reg = RegDst ? rd : rt.
- R-type funct decode:
  - 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x27 nor.
  - 0x2A slt: signed compare, result 1 or 0.
  - 0x10 mfhi → hi_out; 0x12 mflo → lo_out.
  - 0x19 multu, 0x1B divu: alu_result = 0.
  - Any other funct: alu_result = 0.
- add/sub wrap modulo 2^DATA_W; no overflow flag or trap.
- md_op = (ALUOp == 10) && (funct == 0x19 || funct == 0x1B).
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - stall = md_op.
    - If md_op: latch rd1 as multiplicand/dividend, rd2 as multiplier/divisor, latch the op type; count = 0; go to BUSY.
  - BUSY:
    - stall = 1, busy = 1.
    - Performs one iteration per cycle.
    - multu: shift-add on a 2*DATA_W accumulator; if multiplier LSB = 1, add multiplicand to the upper half, then shift right 1.
    - divu: restoring division; shift {rem, quot} left 1, trial-subtract divisor, set quotient bit if the result is non-negative.
    - When count == DATA_W-1: write HI/LO and go to DONE. Otherwise count++.
  - DONE:
    - stall = 0, busy = 0. ID/EX loads the next instruction at this edge.
    - Next state IDLE, unconditionally; this prevents re-issuing the same multu/divu.
- Latency: the stall is high for exactly DATA_W+1 = 33 cycles (1 IDLE + 32 BUSY). HI/LO are visible from the DONE cycle onward.
- Results:
  - multu: HI = product[63:32], LO = product[31:0].
  - divu: LO = quotient, HI = remainder.
- Divide by zero: no special-case path; still 32 cycles. Result is LO = 0xFFFFFFFF, HI = dividend.
- HI/LO change only at the BUSY→DONE transition. mfhi/mflo in the same cycle as that write return the pre-write value; HI/LO are registered.
- Reset (rst = 0, any time including mid-operation):
  - State → IDLE; count, HI, LO and operand registers → 0.
  - stall and busy forced to 0 while rst = 0.
  - Combinational outputs (alu_result, zero, write_reg) follow their inputs.
- After reset release with a multu/divu still presented: a fresh 33-cycle operation starts.
- Non-md instructions in IDLE: stall = 0, zero-cycle latency.

Test Plan:
- add: ALUOp=10, funct=0x20, rd1=0x7FFFFFFF, rd2=1 → alu_result=0x80000000, zero=0. Then sub with rd1=rd2=5 → zero=1. Then ALUOp=00, ALUSrc=1, extend_immed=0xFFFFFFFC, rd1=0x10 → 0x0000000C. RegDst=1/0 selects rd/rt.
- slt signed: rd1=0xFFFFFFFF, rd2=1 → alu_result=1. Swap operands → alu_result=0.
- multu: rd1=0xFFFFFFFF, rd2=0xFFFFFFFF → stall high 33 cycles, busy 32 cycles. Then HI=0xFFFFFFFE, LO=0x00000001. A following mfhi/mflo returns those values.
- divu 100/7 → LO=14, HI=2 after 33 stall cycles. divu 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234.
- Assert rst=0 at BUSY count=10 of a multu → stall=0, busy=0, HI=LO=0 immediately. Release with multu still presented → a full new 33-cycle stall and correct product.
- Back-to-back multu then divu (ID/EX enabled by !stall) → each stalls 33 cycles, the first result is not overwritten early, and no duplicate issue occurs in the DONE cycle.
